// File: rtl/div_hilo.sv
// rtl/div_hilo.sv - iterative 32-bit restoring divider with MIPS HI/LO registers
// Optional div_zero status output enabled by defining DIV_ZERO_FLAG_EN.
module div_hilo (
    input  logic        DIV_clk,
    input  logic        DIV_rst,
    input  logic        DIV_ena,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic        div_zero
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_sign_q;
    logic        r_sign_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_shift;
    logic [32:0] w_dvs_ext;
    logic        w_ge;
    logic [32:0] w_sub;

    assign w_a_neg   = is_signed & dividend[31];
    assign w_b_neg   = is_signed & divisor[31];
    assign w_a_abs   = w_a_neg ? (~dividend + 32'd1) : dividend;
    assign w_b_abs   = w_b_neg ? (~divisor + 32'd1) : divisor;

    // Quotient register doubles as the dividend shift source: its MSB feeds the remainder.
    assign w_shift   = {r_rem[31:0], r_quo[31]};
    assign w_dvs_ext = {1'b0, r_dvs};
    assign w_ge      = (w_shift >= w_dvs_ext);
    assign w_sub     = w_shift - w_dvs_ext;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_next = S_FIXUP;
            S_FIXUP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge DIV_clk) begin
        if (DIV_rst) begin
            r_state <= S_IDLE;
        end else if (DIV_ena) begin
            r_state <= w_next;
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic r_div_zero;

    always_ff @(posedge DIV_clk) begin
        if (DIV_rst) begin
            r_div_zero <= 1'b0;
        end else if (DIV_ena) begin
            if (r_state == S_IDLE && start) begin
                r_div_zero <= 1'b0;
            end else if (r_state == S_FIXUP) begin
                r_div_zero <= (r_dvs == 32'd0);
            end
        end
    end

    assign div_zero = r_div_zero;
`endif

    always_ff @(posedge DIV_clk) begin
        if (DIV_rst) begin
            r_cnt    <= 5'd0;
            r_rem    <= 33'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else if (DIV_ena) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (start) begin
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        r_quo    <= w_a_abs;
                        r_dvs    <= w_b_abs;
                        r_rem    <= 33'd0;
                        r_cnt    <= 5'd0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_sub : w_shift;
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIXUP: begin
                    r_lo   <= r_sign_q ? (~r_quo + 32'd1) : r_quo;
                    r_hi   <= r_sign_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: doc/div_hilo.md
# div_hilo

Iterative 32-bit integer divider with architectural HI/LO registers for the single-cycle MIPS CPU. It executes DIV/DIVU, MTHI and MTLO. It sits beside the ALU, and its HI/LO outputs feed the RegFile write-data mux for MFHI/MFLO. The CPU stalls its PC while `busy` is high.

## Interface
Parameters:
- none; datapath width fixed at 32.

Ports:
- `DIV_clk`  in  1  sole clock, rising edge.
- `DIV_rst`  in  1  synchronous, active-high reset. Overrides `DIV_ena`.
- `DIV_ena`  in  1  module enable. When low, all state (FSM, counter, HI, LO, `done`) holds.
- `start`  in  1  launches a division. Sampled only in IDLE.
- `is_signed`  in  1  1 = DIV, 0 = DIVU. Sampled with `start`.
- `dividend`  in  32  rs value. Sampled with `start`.
- `divisor`  in  32  rt value. Sampled with `start`.
- `mthi`  in  1  write `wdata` into HI.
- `mtlo`  in  1  write `wdata` into LO.
- `wdata`  in  32  data for MTHI/MTLO.
- `HI`  out  32  remainder register.
- `LO`  out  32  quotient register.
- `busy`  out  1  high while a division is in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated by a division.

## Operation
FSM states:
- IDLE → CALC on `start`. The edge that moves to CALC also:
  - latches `sign_q` = sign(dividend) XOR sign(divisor) and `sign_r` = sign(dividend); both are 0 when unsigned;
  - latches the 32-bit magnitudes |dividend| and |divisor|, taking the two's-complement absolute value when signed;
  - clears the 33-bit partial remainder and the 5-bit counter.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude (33-bit) from rem.
  - If the result is non-negative, keep the difference and set the quotient LSB.
  - Increment the counter. After 32 steps (count == 31 at the edge), go to FIXUP.
- FIXUP → IDLE:
  - LO ← `sign_q` ? −quo : quo.
  - HI ← `sign_r` ? −rem : rem.
  - Assert `done` for the following cycle.
- `busy` = (state != IDLE). It is a registered FSM decode with no combinational path from `start`.
- Arithmetic results:
  - 0x80000000 / −1 (signed) gives LO = 0x80000000, HI = 0. No trap.
  - Divide by zero is deterministic. Unsigned: LO = 0xFFFFFFFF, HI = dividend.
  - Signed by zero: HI = dividend; LO = 0xFFFFFFFF if dividend ≥ 0, else 0x00000001.
- `mthi`/`mtlo`:
  - Honoured only in IDLE, written at the edge.
  - Ignored while busy; the CPU stall guarantees they are not issued then.
  - If `start` arrives in the same cycle, both actions take effect, and the division result later overwrites HI/LO.
- `start` while busy is ignored; there is no queueing.
- Reset mid-operation:
  - FSM → IDLE; HI = LO = 0; `busy` = 0; `done` = 0.
  - The in-flight result is discarded.

## Timing
- Reset values: `HI` = 0, `LO` = 0, `busy` = 0, `done` = 0, FSM = IDLE.
- Start sampled at edge E0.
- `busy` is high from after E0 through the cycle ending at E33 (33 cycles).
- CALC iterations occur at edges E1–E32. FIXUP writes HI/LO at E33.
- After E33: `done` = 1 and `busy` = 0 for one cycle, and HI/LO are valid.
- A new `start` may be accepted in that same `done` cycle.
- `DIV_ena` low stretches latency cycle-for-cycle. A pending `done` stays asserted until the enable returns and the next edge clears it.
- HI/LO change only at edges: on reset, MTHI/MTLO, or FIXUP.

## Configuration
- `DIV_ZERO_FLAG_EN`, when defined:
  - adds output `div_zero` (1 bit, reset 0);
  - set at the FIXUP edge when the latched divisor was 0;
  - cleared on the next accepted `start` or on reset.
- Without the macro, the port and its logic are absent; results are unchanged.

## Test plan
- DIVU 100 / 7, start at E0 → `busy` high 33 cycles; at E33 LO = 14, HI = 2; `done` pulses exactly one cycle.
- DIV −7 / 2 (0xFFFFFFF9 / 2) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide by zero:
  - DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
  - DIV −5 / 0 → LO = 1, HI = 0xFFFFFFFB.
  - With `DIV_ZERO_FLAG_EN`, `div_zero` = 1 after E33; the next start clears it.
- Busy interaction: `start` and `mthi` pulsed mid-division → ignored; the original result lands at E33. MTLO 0x1234 in IDLE → LO = 0x1234 next cycle.
- `DIV_rst` asserted at E10 of a division → next cycle HI = LO = 0, `busy` = 0, no `done` pulse.
- `DIV_ena` low for 5 cycles mid-CALC → `done` appears 5 cycles late with the correct quotient; a reset during the enable-low window still clears everything.
